uart_tx_scheduler: RTL and testbench

//  Shares one uart_tx instance between two byte sources: the RX echo path
//  (requester 0) and the periodic timer/din path (requester 1). Each source
//  has a one-entry holding slot. Arbitration is round-robin. The block

---
 rtl/uart_tx_scheduler_pkg.sv | 22 ++
 rtl/uart_tx_scheduler_if.sv | 28 ++
 rtl/uart_tx_scheduler_req_slot.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 126 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the two-source UART transmit scheduler.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_e;

    localparam logic REQ_ECHO  = 1'b0;
    localparam logic REQ_TIMER = 1'b1;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic logic rr_pick(input logic full0, input logic full1,
                                     input logic last_grant);
        if (full0 && full1) begin
            return ~last_grant;
        end
        return full1 ? REQ_TIMER : REQ_ECHO;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Request/transmit bundle between the byte sources, the scheduler and uart_tx.
interface uart_tx_scheduler_if #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned DROP_W = 8
);
    logic              req0_valid;
    logic [DBIT-1:0]   req0_data;
    logic              req1_valid;
    logic [DBIT-1:0]   req1_data;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              busy;
    logic              grant_id;
    logic [DROP_W-1:0] drop0_cnt;
    logic [DROP_W-1:0] drop1_cnt;
    logic              err_timeout;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_done_tick,
        input  tx_start, tx_din, busy, grant_id, drop0_cnt, drop1_cnt, err_timeout
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_done_tick,
        output tx_start, tx_din, busy, grant_id, drop0_cnt, drop1_cnt, err_timeout
    );
endinterface

// File: rtl/uart_tx_scheduler_req_slot.sv
// One-entry holding slot for a byte source, with a saturating drop counter.
module uart_req_slot #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DBIT-1:0]   data_in,
    input  logic              take,
    output logic              full,
    output logic [DBIT-1:0]   data,
    output logic [DROP_W-1:0] drop_cnt
);

    // A take on the same edge as a new valid makes room for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data     <= '0;
            drop_cnt <= '0;
        end else begin
            if (valid_in && (!full || take)) begin
                full <= 1'b1;
                data <= data_in;
            end else if (take) begin
                full <= 1'b0;
            end
            if (valid_in && full && !take && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx between the echo and timer sources,
// with a watchdog that abandons a frame whose done tick never arrives.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned TIMEOUT = 20_000,
    parameter int unsigned DROP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_scheduler_if.slave   bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic              full0, full1;
    logic [DBIT-1:0]   data0, data1;
    logic [DROP_W-1:0] drop0, drop1;
    logic              take0_c, take1_c;

    sched_state_e      state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DBIT-1:0]   din_q, din_d;
    logic              grant_q, grant_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              sel;

    uart_req_slot #(.DBIT(DBIT), .DROP_W(DROP_W)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (bus.req0_valid),
        .data_in  (bus.req0_data),
        .take     (take0_c),
        .full     (full0),
        .data     (data0),
        .drop_cnt (drop0)
    );

    uart_req_slot #(.DBIT(DBIT), .DROP_W(DROP_W)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (bus.req1_valid),
        .data_in  (bus.req1_data),
        .take     (take1_c),
        .full     (full1),
        .data     (data1),
        .drop_cnt (drop1)
    );

    // grant_q doubles as the round-robin history; reset to 1 so echo wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
            din_q   <= '0;
            grant_q <= REQ_TIMER;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            din_q   <= din_d;
            grant_q <= grant_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next state plus the values every registered output takes at the next edge.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        din_d   = din_q;
        grant_d = grant_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        take0_c = 1'b0;
        take1_c = 1'b0;
        sel     = rr_pick(full0, full1, grant_q);

        case (state_q)
            IDLE: begin
                if (full0 || full1) begin
                    state_d = START;
                    din_d   = (sel == REQ_TIMER) ? data1 : data0;
                    grant_d = sel;
                    start_d = 1'b1;
                    take0_c = (sel == REQ_ECHO);
                    take1_c = (sel == REQ_TIMER);
                end
            end
            START: begin
                state_d = WAIT_DONE;
                wd_d    = '0;
            end
            WAIT_DONE: begin
                if (bus.tx_done_tick) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.tx_start    = start_q;
    assign bus.tx_din      = din_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_q;
    assign bus.drop0_cnt   = drop0;
    assign bus.drop1_cnt   = drop1;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a frame scoreboard and a done-tick responder.
module tb_uart_tx_scheduler;

    localparam int unsigned DBIT     = 8;
    localparam int unsigned DROP_W   = 8;
    localparam int unsigned TIMEOUT  = 100;
    localparam int unsigned DONE_LAT = 5;

    typedef struct packed {
        logic       grant;
        logic [7:0] data;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       r0v   = 1'b0;
    logic [7:0] r0d   = 8'h00;
    logic       r1v   = 1'b0;
    logic [7:0] r1d   = 8'h00;
    logic       done_tick = 1'b0;
    bit         auto_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_done_edge = 0;
    int last_gap = 0;
    exp_t exp_q[$];

    uart_tx_scheduler_if #(.DBIT(DBIT), .DROP_W(DROP_W)) bus();

    assign bus.req0_valid   = r0v;
    assign bus.req0_data    = r0d;
    assign bus.req1_valid   = r1v;
    assign bus.req1_data    = r1d;
    assign bus.tx_done_tick = done_tick;

    uart_tx_scheduler #(.DBIT(DBIT), .TIMEOUT(TIMEOUT), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic g, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every tx_start must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.tx_start) begin
            exp_t e;
            start_cnt++;
            last_gap = cyc - last_done_edge;
            if (exp_q.size() == 0) begin
                chk("unexpected_tx_start", 32'(bus.tx_start), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("frame_din", 32'(bus.tx_din), 32'(e.data));
                chk("frame_grant", 32'(bus.grant_id), 32'(e.grant));
            end
        end
    end

    // uart_tx stand-in: answers a start with a done tick DONE_LAT cycles later.
    always begin
        @(negedge clk);
        if (rst_n && bus.tx_start && auto_done) begin
            repeat (DONE_LAT) @(posedge clk);
            #1 done_tick = 1'b1;
            last_done_edge = cyc + 1;
            @(posedge clk);
            #1 done_tick = 1'b0;
        end
    end

    task automatic hold0(input int n, input logic [7:0] d);
        r0v = 1'b1;
        r0d = d;
        repeat (n) @(posedge clk);
        #1 r0v = 1'b0;
    endtask

    task automatic pulse0(input logic [7:0] d);
        @(posedge clk);
        #1 hold0(1, d);
    endtask

    task automatic pulse1(input logic [7:0] d);
        @(posedge clk);
        #1 r1v = 1'b1;
        r1d = d;
        @(posedge clk);
        #1 r1v = 1'b0;
    endtask

    task automatic pulse_both(input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk);
        #1 r0v = 1'b1;
        r0d = d0;
        r1v = 1'b1;
        r1d = d1;
        @(posedge clk);
        #1 r0v = 1'b0;
        r1v = 1'b0;
    endtask

    task automatic wait_start(input int maxc, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tx_start && n < maxc);
        chk(tag, 32'(bus.tx_start), 32'(1));
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || exp_q.size() != 0) && n < maxc);
        chk(tag, 32'(bus.busy), 32'(0));
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic to_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'(0));
        chk({tag, "_tx_din"}, 32'(bus.tx_din), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_grant"}, 32'(bus.grant_id), 32'(1));
        chk({tag, "_drop0"}, 32'(bus.drop0_cnt), 32'(0));
        chk({tag, "_drop1"}, 32'(bus.drop1_cnt), 32'(0));
        chk({tag, "_err"}, 32'(bus.err_timeout), 32'(0));
    endtask

    initial begin
        int s;
        int total;
        int n;
        int sc;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;
        auto_done = 1'b1;

        // Simultaneous requests: echo wins the first tie, timer follows.
        push_exp(1'b0, 8'h11);
        push_exp(1'b1, 8'h22);
        pulse_both(8'h11, 8'h22);
        @(negedge clk);
        chk("t2_no_start_yet", 32'(bus.tx_start), 32'(0));
        @(negedge clk);
        chk("t2_first_start", 32'(bus.tx_start), 32'(1));
        n = 0;
        while (start_cnt < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_two_starts", 32'(start_cnt), 32'(2));
        chk("t2_gap_after_done", 32'(last_gap), 32'(1));
        wait_idle(50, "t2_idle");
        chk("t2_start_total", 32'(start_cnt), 32'(2));

        // Single echo request from idle: start two cycles after capture.
        push_exp(1'b0, 8'h41);
        pulse0(8'h41);
        @(negedge clk);
        chk("t1_start_low", 32'(bus.tx_start), 32'(0));
        chk("t1_busy_low", 32'(bus.busy), 32'(0));
        @(negedge clk);
        chk("t1_start_high", 32'(bus.tx_start), 32'(1));
        chk("t1_din", 32'(bus.tx_din), 32'(8'h41));
        chk("t1_grant", 32'(bus.grant_id), 32'(0));
        chk("t1_busy_high", 32'(bus.busy), 32'(1));
        @(negedge clk);
        chk("t1_start_one_cycle", 32'(bus.tx_start), 32'(0));
        chk("t1_din_stable", 32'(bus.tx_din), 32'(8'h41));
        wait_idle(50, "t1_idle");

        // Two timer requests while a frame is in flight: second one dropped.
        push_exp(1'b0, 8'h55);
        pulse0(8'h55);
        wait_start(10, "t3_start");
        push_exp(1'b1, 8'h33);
        pulse1(8'h33);
        pulse1(8'h44);
        chk("t3_drop1_now", 32'(bus.drop1_cnt), 32'(1));
        wait_idle(60, "t3_idle");
        chk("t3_drop1", 32'(bus.drop1_cnt), 32'(1));
        chk("t3_drop0", 32'(bus.drop0_cnt), 32'(0));
        chk("t3_start_total", 32'(start_cnt), 32'(5));

        // Lost done tick: watchdog aborts, pending timer byte goes next.
        auto_done = 1'b0;
        push_exp(1'b0, 8'h66);
        pulse0(8'h66);
        wait_start(10, "t4_start");
        s = cyc;
        push_exp(1'b1, 8'h77);
        pulse1(8'h77);
        to_cyc(s + 100);
        chk("t4_err_not_yet", 32'(bus.err_timeout), 32'(0));
        chk("t4_busy_in_wait", 32'(bus.busy), 32'(1));
        @(negedge clk);
        chk("t4_err_pulse", 32'(bus.err_timeout), 32'(1));
        chk("t4_busy_after_abort", 32'(bus.busy), 32'(0));
        chk("t4_no_start_on_abort", 32'(bus.tx_start), 32'(0));
        auto_done = 1'b1;
        @(negedge clk);
        chk("t4_err_one_cycle", 32'(bus.err_timeout), 32'(0));
        chk("t4_pending_start", 32'(bus.tx_start), 32'(1));
        chk("t4_pending_din", 32'(bus.tx_din), 32'(8'h77));
        wait_idle(40, "t4_idle");

        // Drop counter saturation: 259 echo pulses into a held slot.
        auto_done = 1'b0;
        total = 0;
        push_exp(1'b0, 8'hA0);
        pulse0(8'hA0);
        wait_start(10, "t5_start0");
        for (int r = 0; r < 3; r++) begin
            push_exp(1'b0, 8'(8'hA1 + r));
            pulse0(8'(8'hA1 + r));
            n = (r < 2) ? 95 : 69;
            hold0(n, 8'hEE);
            total += n;
            wait_start(150, "t5_next_start");
            chk("t5_drop0", 32'(bus.drop0_cnt), 32'((total > 255) ? 255 : total));
        end
        wait_idle(150, "t5_idle");
        chk("t5_drop0_saturated", 32'(bus.drop0_cnt), 32'(255));

        // Reset in WAIT_DONE with both slots full: nothing survives.
        push_exp(1'b0, 8'hB0);
        pulse0(8'hB0);
        wait_start(10, "t6_start");
        pulse0(8'hB1);
        pulse1(8'hB2);
        @(negedge clk);
        chk("t6_busy_before_reset", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_values("t6_in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sc = start_cnt;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t6_no_start_after_release", 32'(bus.tx_start), 32'(0));
        end
        chk("t6_start_total", 32'(start_cnt), 32'(sc));
        chk("t6_busy", 32'(bus.busy), 32'(0));
        chk("t6_queue", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
